// File: rtl/usb_pulpino_pkg.sv
// Shared definitions for the USB->Pulpino byte channel blocks.
package usb_pulpino_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned NUM_BYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_ERROR
  } tx_state_e;

endpackage

// File: rtl/flicker_edge_detect.sv
// Turns a toggle ("flicker") input into a one-cycle event pulse.
// The first clock after reset only captures the input level, so a flicker
// that is already high when reset is released never produces an event.
module flicker_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic flk_i,
  output logic evt_o
);

  logic prev_q;
  logic armed_q;

  // Track the previous flicker level; arm only after the first sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= flk_i;
      armed_q <= 1'b1;
    end
  end

  assign evt_o = armed_q & (flk_i ^ prev_q);

endmodule

// File: rtl/usb_pulpino_word_tx_ctrl.sv
// Word transmit controller: accepts a word, presents it LSB-first one byte
// at a time with a write flicker, waits for each read-flicker ack, and
// toggles word_done_flk_o when the whole word has been acknowledged.
module usb_pulpino_word_tx_ctrl
  import usb_pulpino_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = NUM_BYTES_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BYTE_W*NUM_BYTES-1:0] word_i,
  input  logic                        word_valid_i,
  output logic                        word_ready_o,
  output logic [BYTE_W-1:0]           byte_o,
  output logic                        byte_write_flk_o,
  input  logic                        byte_read_flk_i,
  output logic                        word_done_flk_o,
  output logic                        busy_o,
  output logic                        err_timeout_o,
  output logic                        err_spurious_o,
  input  logic                        clr_err_i
);

  localparam int unsigned WORD_W = BYTE_W * NUM_BYTES;
  localparam int unsigned IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [TO_W:0]    TO_LIMIT = (TO_W + 1)'(ACK_TIMEOUT);

  tx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [TO_W-1:0]   cnt_q;
  logic [TO_W:0]     cnt_inc;
  logic [WORD_W-1:0] shreg_q;
  logic [BYTE_W-1:0] byte_q;
  logic              wr_flk_q;
  logic              done_flk_q;
  logic              err_to_q;
  logic              err_sp_q;
  logic              ack_evt;

  logic load_word;
  logic next_byte;
  logic finish_word;
  logic set_to;
  logic set_sp;

  flicker_edge_detect u_ack_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .flk_i (byte_read_flk_i),
    .evt_o (ack_evt)
  );

  // The counter starts at 0 in the SEND cycle and also counts that cycle,
  // so the terminal check fires exactly ACK_TIMEOUT cycles after the toggle.
  assign cnt_inc = {1'b0, cnt_q} + {{TO_W{1'b0}}, 1'b1};

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_d     = state_q;
    load_word   = 1'b0;
    next_byte   = 1'b0;
    finish_word = 1'b0;
    set_to      = 1'b0;
    set_sp      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        set_sp = ack_evt;
        if (word_valid_i) begin
          load_word = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        set_sp  = ack_evt;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_evt) begin
          if (idx_q == LAST_IDX) begin
            finish_word = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            next_byte = 1'b1;
            state_d   = ST_SEND;
          end
        end else if (cnt_inc >= TO_LIMIT) begin
          set_to  = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (clr_err_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and flicker/error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      byte_q     <= '0;
      wr_flk_q   <= 1'b0;
      done_flk_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // The byte and its flicker are registered on entry to SEND so both are
      // already visible during the SEND cycle itself.
      if (load_word) begin
        byte_q   <= word_i[BYTE_W-1:0];
        shreg_q  <= word_i >> BYTE_W;
        idx_q    <= '0;
        cnt_q    <= '0;
        wr_flk_q <= ~wr_flk_q;
      end else if (next_byte) begin
        byte_q   <= shreg_q[BYTE_W-1:0];
        shreg_q  <= shreg_q >> BYTE_W;
        idx_q    <= idx_q + IDX_W'(1);
        cnt_q    <= '0;
        wr_flk_q <= ~wr_flk_q;
      end else if (state_q == ST_SEND || state_q == ST_WAIT_ACK) begin
        cnt_q <= cnt_inc[TO_W-1:0];
      end

      if (finish_word) done_flk_q <= ~done_flk_q;

      // A new error event in the same cycle as a clear takes priority.
      if (clr_err_i) begin
        err_to_q <= 1'b0;
        err_sp_q <= 1'b0;
      end
      if (set_to) err_to_q <= 1'b1;
      if (set_sp) err_sp_q <= 1'b1;
    end
  end

  assign word_ready_o     = (state_q == ST_IDLE);
  assign busy_o           = (state_q != ST_IDLE);
  assign byte_o           = byte_q;
  assign byte_write_flk_o = wr_flk_q;
  assign word_done_flk_o  = done_flk_q;
  assign err_timeout_o    = err_to_q;
  assign err_spurious_o   = err_sp_q;

endmodule

// File: tb/tb_usb_pulpino_word_tx_ctrl.sv
// Directed + randomized bench for usb_pulpino_word_tx_ctrl. Expected bytes
// come from slicing the word arithmetically; flicker levels are tracked as
// the parity of the events the bench expects.
module tb_usb_pulpino_word_tx_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [7:0]  byte_o;
  logic        byte_write_flk_o;
  logic        byte_read_flk_i;
  logic        word_done_flk_o;
  logic        busy_o;
  logic        err_timeout_o;
  logic        err_spurious_o;
  logic        clr_err_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_wr   = 1'b0;
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  usb_pulpino_word_tx_ctrl #(
    .NUM_BYTES   (NB),
    .ACK_TIMEOUT (TO),
    .TO_W        (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .word_i           (word_i),
    .word_valid_i     (word_valid_i),
    .word_ready_o     (word_ready_o),
    .byte_o           (byte_o),
    .byte_write_flk_o (byte_write_flk_o),
    .byte_read_flk_i  (byte_read_flk_i),
    .word_done_flk_o  (word_done_flk_o),
    .busy_o           (busy_o),
    .err_timeout_o    (err_timeout_o),
    .err_spurious_o   (err_spurious_o),
    .clr_err_i        (clr_err_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called the cycle after the accepting edge. Byte 0 is acked first_dly
  // cycles after its toggle, later bytes dly cycles after theirs.
  task automatic run_bytes(input logic [31:0] w, input int unsigned first_dly,
                           input int unsigned dly);
    logic [7:0] q[$];
    for (int unsigned k = 0; k < NB; k++) q.push_back(8'((w >> (8 * k)) & 32'hFF));
    for (int unsigned k = 0; k < NB; k++) begin
      exp_wr = ~exp_wr;
      check("wr_flk", {31'd0, byte_write_flk_o}, {31'd0, exp_wr});
      check("byte", {24'd0, byte_o}, {24'd0, q.pop_front()});
      check("busy", {31'd0, busy_o}, 32'd1);
      tick((k == 0) ? first_dly : dly);
      check("byte_held", {31'd0, err_timeout_o}, 32'd0);
      byte_read_flk_i = ~byte_read_flk_i;
      if (k == NB - 1) check("done_early", {31'd0, word_done_flk_o}, {31'd0, exp_done});
      tick();
    end
    exp_done = ~exp_done;
    check("done", {31'd0, word_done_flk_o}, {31'd0, exp_done});
    check("ready_after", {31'd0, word_ready_o}, 32'd1);
    check("no_spurious", {31'd0, err_spurious_o}, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned dly);
    check("ready_before", {31'd0, word_ready_o}, 32'd1);
    word_i       = w;
    word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    word_i       = $urandom;
    run_bytes(w, dly, dly);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] w2;

    // 1: reset with the read flicker already high.
    rst_n = 1'b0; byte_read_flk_i = 1'b1; word_valid_i = 1'b0;
    word_i = '0; clr_err_i = 1'b0;
    #1;
    check("rst_ready", {31'd0, word_ready_o}, 32'd1);
    check("rst_wr", {31'd0, byte_write_flk_o}, 32'd0);
    check("rst_byte", {24'd0, byte_o}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("rel_spurious", {31'd0, err_spurious_o}, 32'd0);
    check("rel_ready", {31'd0, word_ready_o}, 32'd1);
    check("rel_busy", {31'd0, busy_o}, 32'd0);
    check("rel_wr", {31'd0, byte_write_flk_o}, 32'd0);
    check("rel_done", {31'd0, word_done_flk_o}, 32'd0);

    // 2: fixed word, ack 3 cycles after each toggle.
    send_word(32'h1234_1236, 3);

    // 3: no ack on byte 0 -> timeout exactly TO cycles after the toggle.
    w = $urandom;
    word_i = w; word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    exp_wr = ~exp_wr;
    check("to_wr", {31'd0, byte_write_flk_o}, {31'd0, exp_wr});
    tick(TO - 1);
    check("to_early", {31'd0, err_timeout_o}, 32'd0);
    tick();
    check("to_set", {31'd0, err_timeout_o}, 32'd1);
    check("to_ready", {31'd0, word_ready_o}, 32'd0);
    check("to_byte_held", {24'd0, byte_o}, {24'd0, w[7:0]});
    byte_read_flk_i = ~byte_read_flk_i;
    tick(2);
    check("err_ack_ignored", {31'd0, err_spurious_o}, 32'd0);
    check("err_busy", {31'd0, busy_o}, 32'd1);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("clr_to", {31'd0, err_timeout_o}, 32'd0);
    check("clr_ready", {31'd0, word_ready_o}, 32'd1);
    check("clr_no_done", {31'd0, word_done_flk_o}, {31'd0, exp_done});

    // Ack landing on the terminal-count cycle wins over the timeout.
    w = $urandom;
    word_i = w; word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    run_bytes(w, TO - 1, 1);
    check("tie_no_to", {31'd0, err_timeout_o}, 32'd0);

    // 4: ack toggle while idle.
    byte_read_flk_i = ~byte_read_flk_i;
    tick();
    check("sp_set", {31'd0, err_spurious_o}, 32'd1);
    check("sp_idle", {31'd0, busy_o}, 32'd0);
    check("sp_no_to", {31'd0, err_timeout_o}, 32'd0);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("sp_clr", {31'd0, err_spurious_o}, 32'd0);
    check("sp_ready", {31'd0, word_ready_o}, 32'd1);

    // 5: back-to-back words with valid held, zero-delay acks.
    w  = $urandom;
    w2 = $urandom;
    word_i = w; word_valid_i = 1'b1;
    tick();
    word_i = w2;
    run_bytes(w, 1, 1);
    tick();
    word_valid_i = 1'b0;
    run_bytes(w2, 1, 1);

    // 6: reset during WAIT_ACK of byte 2.
    w = $urandom;
    word_i = w; word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    exp_wr = ~exp_wr;
    tick(1);
    byte_read_flk_i = ~byte_read_flk_i;
    tick();
    exp_wr = ~exp_wr;
    check("mid_wr", {31'd0, byte_write_flk_o}, {31'd0, exp_wr});
    check("mid_byte", {24'd0, byte_o}, {24'd0, w[15:8]});
    tick();
    #2;
    rst_n = 1'b0;
    byte_read_flk_i = 1'b0;
    exp_wr = 1'b0;
    exp_done = 1'b0;
    #1;
    check("arst_wr", {31'd0, byte_write_flk_o}, 32'd0);
    check("arst_done", {31'd0, word_done_flk_o}, 32'd0);
    check("arst_byte", {24'd0, byte_o}, 32'd0);
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_ready", {31'd0, word_ready_o}, 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_word($urandom, 2);

    // Randomized words and ack delays.
    for (int i = 0; i < 8; i++) begin
      send_word($urandom, $urandom_range(1, 6));
      tick($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
